// File: rtl/data_wb_if_pkg.sv
// -----------------------------------------------------------------------------
// data_wb_if_pkg -- shared definitions for the data-side Wishbone interface.
//
// Contents:
//   - bus widths (address/data, byte select, stall vector)
//   - ZeroWord, ChipEnable, WriteEnable encodings
//   - 2-bit FSM state encoding (IDLE, BUSY, WAIT_FOR_STALL)
//   - wb_req_t: the registered Wishbone master request bundle
// -----------------------------------------------------------------------------
package data_wb_if_pkg;

    localparam int BusWidth   = 32;
    localparam int SelWidth   = 4;
    localparam int StallWidth = 6;

    localparam logic [BusWidth-1:0] ZeroWord    = '0;
    localparam logic                ChipEnable  = 1'b1;
    localparam logic                WriteEnable = 1'b1;

    typedef enum logic [1:0] {
        IDLE           = 2'b00,
        BUSY           = 2'b01,
        WAIT_FOR_STALL = 2'b10
    } wb_state_e;

    // Everything the master drives onto the bus, registered as one unit so
    // that a completed or aborted access can be cleared with a single '0.
    typedef struct packed {
        logic [BusWidth-1:0] addr;
        logic [BusWidth-1:0] data;
        logic                we;
        logic [SelWidth-1:0] sel;
        logic                stb;
        logic                cyc;
    } wb_req_t;

endpackage

// File: rtl/data_wb_if.sv
// -----------------------------------------------------------------------------
// data_wb_if -- bridges the pipeline memory-access stage to a Wishbone master.
//
// A CPU access seen in IDLE is registered onto the bus and the pipeline is
// stalled until the slave acks. Read data is passed straight through in the
// ack cycle; if the pipeline is still stalled by someone else at that point,
// the data is parked in rd_buf and presented from WAIT_FOR_STALL until the
// stall clears. A flush aborts any access in flight.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   stall_i[5:0]      pipeline stall vector
//   flush_i           pipeline flush
//   cpu_ce/we/addr/sel/data_i   access request from the memory-access stage
//   cpu_data_o        load data back to the memory-access stage
//   stallreq          stall request to the stall controller (combinational)
//   wb_*              Wishbone master signals (outputs registered)
//   bus_err_o         one-cycle pulse when an access is aborted on timeout
//
// Build option:
//   WB_TIMEOUT_EN     when defined, an access that sees no ack for TIMEOUT
//                     BUSY cycles is aborted and bus_err_o pulses. When not
//                     defined, BUSY waits forever and bus_err_o is tied low.
// -----------------------------------------------------------------------------
module data_wb_if
    import data_wb_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [StallWidth-1:0] stall_i,
    input  logic                  flush_i,

    input  logic                  cpu_ce_i,
    input  logic                  cpu_we_i,
    input  logic [BusWidth-1:0]   cpu_addr_i,
    input  logic [SelWidth-1:0]   cpu_sel_i,
    input  logic [BusWidth-1:0]   cpu_data_i,
    output logic [BusWidth-1:0]   cpu_data_o,
    output logic                  stallreq,

    input  logic [BusWidth-1:0]   wb_data_i,
    input  logic                  wb_ack_i,
    output logic [BusWidth-1:0]   wb_addr_o,
    output logic [BusWidth-1:0]   wb_data_o,
    output logic                  wb_we_o,
    output logic [SelWidth-1:0]   wb_sel_o,
    output logic                  wb_stb_o,
    output logic                  wb_cyc_o,

    output logic                  bus_err_o
);

    wb_state_e           state_q;
    wb_req_t             wb_q;
    logic [BusWidth-1:0] rd_buf_q;
    logic                err_pulse;   // high in the cycle after a timeout abort

    wire start_access = (cpu_ce_i == ChipEnable) && !flush_i && !err_pulse;
    wire is_read      = (wb_q.we != WriteEnable);

`ifdef WB_TIMEOUT_EN
    localparam int CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q;
    logic            bus_err_q;

    assign err_pulse = bus_err_q;
    assign bus_err_o = bus_err_q;
`else
    wire unused_timeout = |TIMEOUT;

    assign err_pulse = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    // NOTE: all state, including the rd_buf data register, uses non-blocking
    // assignments and is cleared by the async reset, so the bus strobes drop
    // the moment rst goes low rather than at the next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wb_q      <= '0;
            rd_buf_q  <= ZeroWord;
`ifdef WB_TIMEOUT_EN
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
`ifdef WB_TIMEOUT_EN
            bus_err_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (start_access) begin
                        wb_q     <= '{addr: cpu_addr_i, data: cpu_data_i,
                                      we: cpu_we_i, sel: cpu_sel_i,
                                      stb: 1'b1, cyc: 1'b1};
                        rd_buf_q <= ZeroWord;
                        state_q  <= BUSY;
`ifdef WB_TIMEOUT_EN
                        cnt_q    <= '0;
`endif
                    end
                end

                BUSY: begin
                    // Flush wins over an ack arriving in the same cycle.
                    if (flush_i) begin
                        wb_q     <= '0;
                        rd_buf_q <= ZeroWord;
                        state_q  <= IDLE;
                    end else if (wb_ack_i) begin
                        wb_q <= '0;
                        if (is_read) begin
                            rd_buf_q <= wb_data_i;
                        end
                        state_q <= (stall_i != '0) ? WAIT_FOR_STALL : IDLE;
                    end
`ifdef WB_TIMEOUT_EN
                    else if (cnt_q == CntLast) begin
                        wb_q      <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end

                WAIT_FOR_STALL: begin
                    if (flush_i) begin
                        rd_buf_q <= ZeroWord;
                        state_q  <= IDLE;
                    end else if (stall_i == '0) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        stallreq   = 1'b0;
        cpu_data_o = ZeroWord;
        unique case (state_q)
            IDLE: stallreq = start_access;
            BUSY: begin
                stallreq = !wb_ack_i;
                if (wb_ack_i && is_read) begin
                    cpu_data_o = wb_data_i;
                end
            end
            WAIT_FOR_STALL: cpu_data_o = rd_buf_q;
            default: ;
        endcase
    end

    assign wb_addr_o = wb_q.addr;
    assign wb_data_o = wb_q.data;
    assign wb_we_o   = wb_q.we;
    assign wb_sel_o  = wb_q.sel;
    assign wb_stb_o  = wb_q.stb;
    assign wb_cyc_o  = wb_q.cyc;

endmodule

// File: tb/tb_data_wb_if.sv
// -----------------------------------------------------------------------------
// tb_data_wb_if -- directed bench for data_wb_if.
//
// The stimulus process drives one cycle at a time (inputs change 1 ns after
// the rising edge) and pushes the hand-computed expected outputs for that
// cycle into exp_q. A monitor pops and compares on every falling edge.
// The timeout scenario depends on WB_TIMEOUT_EN, matching the DUT build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_wb_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_data_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic [31:0] wb_addr_o, wb_data_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o, wb_cyc_o;
    logic        bus_err_o;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    data_wb_if #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stallreq   (stallreq),
        .wb_data_i  (wb_data_i),
        .wb_ack_i   (wb_ack_i),
        .wb_addr_o  (wb_addr_o),
        .wb_data_o  (wb_data_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .bus_err_o  (bus_err_o)
    );

    typedef struct {
        string       name;
        logic        stallreq;
        logic [31:0] rdata;
        logic        cyc;      // stb is expected to equal cyc
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        bus_err;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the next expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".stallreq"}, 32'(stallreq),  32'(e.stallreq));
            check({e.name, ".cpu_data"}, cpu_data_o,     e.rdata);
            check({e.name, ".cyc"},      32'(wb_cyc_o),  32'(e.cyc));
            check({e.name, ".stb"},      32'(wb_stb_o),  32'(e.cyc));
            check({e.name, ".we"},       32'(wb_we_o),   32'(e.we));
            check({e.name, ".sel"},      32'(wb_sel_o),  32'(e.sel));
            check({e.name, ".addr"},     wb_addr_o,      e.addr);
            check({e.name, ".wdata"},    wb_data_o,      e.wdata);
            check({e.name, ".bus_err"},  32'(bus_err_o), 32'(e.bus_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic ce, input logic we, input logic [31:0] addr,
                           input logic [3:0] sel, input logic [31:0] data);
        cpu_ce_i   = ce;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_sel_i  = sel;
        cpu_data_i = data;
    endtask

    task automatic set_bus(input logic ack, input logic [31:0] rdata,
                           input logic [5:0] stall, input logic flush);
        wb_ack_i  = ack;
        wb_data_i = rdata;
        stall_i   = stall;
        flush_i   = flush;
    endtask

    task automatic expect_cycle(input string name, input logic stallreq_e,
                                input logic [31:0] rdata, input logic cyc,
                                input logic we, input logic [3:0] sel,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic bus_err);
        exp_t e;
        e = '{name: name, stallreq: stallreq_e, rdata: rdata, cyc: cyc, we: we,
              sel: sel, addr: addr, wdata: wdata, bus_err: bus_err};
        exp_q.push_back(e);
    endtask

    // Bus idle, nothing returned: the common expectation.
    task automatic expect_idle(input string name, input logic stallreq_e);
        expect_cycle(name, stallreq_e, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_bus(1'b0, 32'h0, 6'h0, 1'b0);

        // Reset: outputs zero; stallreq follows ce/flush only.
        tick(); expect_idle("reset_idle", 1'b0);
        tick(); set_cpu(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        expect_idle("reset_ce", 1'b1);

        // Read, ack on the third BUSY cycle.
        tick(); rst = 1'b1; expect_idle("rd_req", 1'b1);
        tick(); expect_cycle("rd_busy1", 1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0);
        tick(); expect_cycle("rd_busy2", 1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0);
        tick(); set_bus(1'b1, 32'hDEADBEEF, 6'h0, 1'b0);
        expect_cycle("rd_ack", 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0);
        tick(); set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); set_bus(1'b0, 32'h0, 6'h0, 1'b0);
        expect_idle("rd_done", 1'b0);

        // Write, immediate ack; junk on wb_data_i must not reach cpu_data_o.
        tick(); set_cpu(1'b1, 1'b1, 32'h200, 4'b0011, 32'h12345678);
        expect_idle("wr_req", 1'b1);
        tick(); set_bus(1'b1, 32'hAAAA5555, 6'h0, 1'b0);
        expect_cycle("wr_ack", 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h200, 32'h12345678, 1'b0);
        tick(); set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); set_bus(1'b0, 32'h0, 6'h0, 1'b0);
        expect_idle("wr_done", 1'b0);

        // Write acked under stall: WAIT_FOR_STALL returns 0, not the ack data.
        tick(); set_cpu(1'b1, 1'b1, 32'h204, 4'hF, 32'hCAFE0001);
        expect_idle("wrs_req", 1'b1);
        tick(); set_bus(1'b1, 32'h99999999, 6'h0F, 1'b0);
        expect_cycle("wrs_ack", 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h204, 32'hCAFE0001, 1'b0);
        tick(); set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); set_bus(1'b0, 32'h77777777, 6'h0F, 1'b0);
        expect_idle("wrs_wait", 1'b0);
        tick(); set_bus(1'b0, 32'h0, 6'h0, 1'b0);
        expect_idle("wrs_release", 1'b0);

        // Read acked under stall_i=001111, held for two more cycles.
        tick(); set_cpu(1'b1, 1'b0, 32'h300, 4'hF, 32'h0);
        expect_idle("st_req", 1'b1);
        tick(); set_bus(1'b1, 32'hCAFEF00D, 6'b001111, 1'b0);
        expect_cycle("st_ack", 1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0);
        tick(); set_bus(1'b0, 32'h11111111, 6'b001111, 1'b0);
        expect_cycle("st_wait1", 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        tick(); expect_cycle("st_wait2", 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        tick(); set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); set_bus(1'b0, 32'h11111111, 6'h0, 1'b0);
        expect_cycle("st_release", 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        tick(); expect_idle("st_idle", 1'b0);

        // Flush in WAIT_FOR_STALL forces IDLE although stall stays high.
        tick(); set_cpu(1'b1, 1'b0, 32'h304, 4'hF, 32'h0); set_bus(1'b0, 32'h0, 6'h0, 1'b0);
        expect_idle("wf_req", 1'b1);
        tick(); set_bus(1'b1, 32'h0BADF00D, 6'h01, 1'b0);
        expect_cycle("wf_ack", 1'b0, 32'h0BADF00D, 1'b1, 1'b0, 4'hF, 32'h304, 32'h0, 1'b0);
        tick(); set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); set_bus(1'b0, 32'h0, 6'h01, 1'b1);
        expect_cycle("wf_flush", 1'b0, 32'h0BADF00D, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        tick(); set_bus(1'b0, 32'h0, 6'h01, 1'b0);
        expect_idle("wf_idle", 1'b0);

        // Flush with simultaneous ack in the second BUSY cycle: flush wins,
        // so no WAIT_FOR_STALL even though stall is set.
        tick(); set_cpu(1'b1, 1'b0, 32'h400, 4'hF, 32'h0); set_bus(1'b0, 32'h0, 6'h0, 1'b0);
        expect_idle("fl_req", 1'b1);
        tick(); expect_cycle("fl_busy1", 1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 1'b0);
        tick(); set_bus(1'b1, 32'h00000055, 6'h0F, 1'b1);
        expect_cycle("fl_busy2", 1'b0, 32'h00000055, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 1'b0);
        tick(); set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); set_bus(1'b0, 32'h0, 6'h0F, 1'b0);
        expect_idle("fl_idle", 1'b0);

        // Flush in IDLE suppresses the request.
        tick(); set_cpu(1'b1, 1'b0, 32'h500, 4'hF, 32'h0); set_bus(1'b0, 32'h0, 6'h0, 1'b1);
        expect_idle("fi_req", 1'b0);
        tick(); set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); set_bus(1'b0, 32'h0, 6'h0, 1'b0);
        expect_idle("fi_none", 1'b0);

`ifdef WB_TIMEOUT_EN
        // No ack: abort after 4 BUSY cycles, bus_err pulses once with stallreq low.
        tick(); set_cpu(1'b1, 1'b0, 32'h600, 4'hF, 32'h0);
        expect_idle("to_req", 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(); expect_cycle($sformatf("to_busy%0d", i + 1), 1'b1, 32'h0, 1'b1, 1'b0,
                                 4'hF, 32'h600, 32'h0, 1'b0);
        end
        tick(); expect_cycle("to_err", 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        tick(); set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        expect_idle("to_after", 1'b0);
`else
        // No timeout logic: BUSY holds stb/cyc for as long as ack is absent.
        tick(); set_cpu(1'b1, 1'b0, 32'h600, 4'hF, 32'h0);
        expect_idle("nt_req", 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick(); expect_cycle($sformatf("nt_busy%0d", i + 1), 1'b1, 32'h0, 1'b1, 1'b0,
                                 4'hF, 32'h600, 32'h0, 1'b0);
        end
        tick(); set_bus(1'b1, 32'h600D600D, 6'h0, 1'b0);
        expect_cycle("nt_ack", 1'b0, 32'h600D600D, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 1'b0);
        tick(); set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); set_bus(1'b0, 32'h0, 6'h0, 1'b0);
        expect_idle("nt_idle", 1'b0);
`endif

        // Asynchronous reset in the middle of a BUSY cycle.
        tick(); set_cpu(1'b1, 1'b0, 32'h700, 4'hF, 32'h0);
        expect_idle("ar_req", 1'b1);
        tick(); expect_idle("ar_in_reset", 1'b1);
        #2 rst = 1'b0;
        #1;
        check("ar_cyc_async", 32'(wb_cyc_o), 32'h0);
        check("ar_stb_async", 32'(wb_stb_o), 32'h0);
        check("ar_addr_async", wb_addr_o, 32'h0);
        tick(); rst = 1'b1; set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        expect_idle("ar_release", 1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/data_wb_if.md
DATA_WB_IF -- requirements
Module: data_wb_if

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of BUSY cycles without ack before abort (used only when the timeout feature is compiled in).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low (rst=0 resets).
REQ-004 SHALL have port stall_i, input, 6, the pipeline stall vector from the stall controller.
REQ-005 SHALL have port flush_i, input, 1, the pipeline flush.
REQ-006 SHALL have CPU-side inputs: cpu_ce_i (1), cpu_we_i (1), cpu_addr_i (32), cpu_sel_i (4), cpu_data_i (32), driven by the memory-access stage outputs.
REQ-007 SHALL have port cpu_data_o, output, 32, the load data returned to the memory-access stage.
REQ-008 SHALL have port stallreq, output, 1, the stall request to the stall controller.
REQ-009 SHALL have Wishbone master ports: wb_data_i in 32, wb_ack_i in 1, wb_addr_o out 32, wb_data_o out 32, wb_we_o out 1, wb_sel_o out 4, wb_stb_o out 1, wb_cyc_o out 1.
REQ-010 SHALL have port bus_err_o, output, 1, a single-cycle timeout-abort pulse.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, WAIT_FOR_STALL.
REQ-012 In IDLE with cpu_ce_i=1 and flush_i=0, SHALL register wb_addr_o/wb_data_o/wb_we_o/wb_sel_o from the cpu_* inputs, set wb_stb_o=wb_cyc_o=1, clear rd_buf, and enter BUSY next cycle.
REQ-013 In BUSY with wb_ack_i=1, SHALL clear stb/cyc/we/sel/addr/data, latch rd_buf=wb_data_i if wb_we_o=0, then go to WAIT_FOR_STALL if stall_i!=0, else to IDLE.
REQ-014 In BUSY with flush_i=1, SHALL abort: clear all wb_* outputs and rd_buf, and go to IDLE; flush takes priority over a simultaneous ack.
REQ-015 In WAIT_FOR_STALL, SHALL return to IDLE when stall_i==0 and hold otherwise; flush_i=1 SHALL force IDLE with rd_buf cleared.
REQ-016 stallreq SHALL be combinational: 1 in IDLE when cpu_ce_i=1 and flush_i=0; 1 in BUSY until the ack cycle; 0 otherwise.
REQ-017 cpu_data_o SHALL be combinational: wb_data_i in BUSY during the ack cycle of a read; rd_buf in WAIT_FOR_STALL; 0 otherwise.
REQ-018 Minimum access latency SHALL be 2 cycles (request cycle plus ack cycle); stb/cyc SHALL remain asserted for each BUSY cycle without ack.
REQ-019 Write accesses SHALL return cpu_data_o=0 and leave rd_buf unchanged.

Reset
REQ-020 While rst=0, state SHALL be IDLE and wb_*_o, rd_buf, bus_err_o and the timeout counter SHALL be 0; in this state stallreq depends only on cpu_ce_i and flush_i, and cpu_data_o=0.
REQ-021 Reset asserted mid-BUSY SHALL drop wb_cyc_o/wb_stb_o immediately (asynchronously).

Configuration
REQ-022 With WB_TIMEOUT_EN defined, SHALL count BUSY cycles; after TIMEOUT cycles without ack SHALL clear wb_* outputs, go to IDLE, and pulse bus_err_o for 1 cycle with stallreq=0 and cpu_data_o=0 in that cycle.
REQ-023 Without WB_TIMEOUT_EN, SHALL include no counter, tie bus_err_o to 0, and wait in BUSY indefinitely.

Structure
REQ-024 State encodings (2-bit), ZeroWord, ChipEnable/WriteEnable and bus widths SHALL live in the shared define file.
REQ-025 SHALL be a single module with no sub-module; the FSM, rd_buf and the optional counter are inline.

Verification
REQ-026 Read: ce=1, we=0, addr=0x100, ack after 3 cycles with data 0xDEADBEEF -> stallreq high 3 cycles, cpu_data_o=0xDEADBEEF in the ack cycle, then IDLE.
REQ-027 Write: ce=1, we=1, sel=4'b0011, data=0x12345678, immediate ack -> wb_sel_o=0011 and wb_data_o=0x12345678 for 1 cycle; cpu_data_o=0.
REQ-028 Stall hold: read acked while stall_i=6'b001111 for 2 more cycles -> WAIT_FOR_STALL, cpu_data_o=rd_buf stable, then IDLE.
REQ-029 Flush: flush_i=1 in the second BUSY cycle with ack -> wb_cyc_o=0 next cycle, state IDLE, rd_buf=0.
REQ-030 Timeout (WB_TIMEOUT_EN, TIMEOUT=4): no ack -> bus_err_o pulses once after 4 BUSY cycles, stallreq=0 in that cycle.
REQ-031 Async reset: rst=0 mid-BUSY, between clock edges -> wb_cyc_o=0 without waiting for a clock edge.
